dma_copy: RTL and testbench

- Word-copy DMA engine that acts as a second initiator on the CPU-style native memory bus (valid/ready/addr/wdata/wstrb/rdata).
- The CPU programs it through a small register responder port: source, destination, length, control/status.
- It moves 32-bit words, for example from work RAM into video RAM, and raises a level IRQ on completion.
- It sits beside the CPU. The top-level arbiter grants it the bus while the CPU is stalled.

---
 rtl/dma_copy.sv | 149 ++++++++++++++
 tb/tb_dma_copy.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_copy.sv
// Word-copy DMA: reads a 32-bit word from SRC, writes it to DST, repeats LEN times, then raises irq.
// Latency: first bus request one cycle after the start write; 6 cycles per word with a 1-cycle responder.
// Backpressure: each beat holds m_valid/m_addr/m_wdata/m_wstrb stable until m_ready, then drops m_valid for one cycle.
module dma_copy #(
  parameter int LEN_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_we,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_data,
  output logic [31:0] reg_q,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata,
  output logic        irq,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RGAP,
    S_WR,
    S_WGAP
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            src_q, dst_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [31:0]            wsrc_q, wdst_q, buf_q;
  logic [LEN_WIDTH-1:0]   cnt_q;
  logic                   done_q;
  logic                   idle;
  logic                   ctrl_wr;
  logic                   start;

  assign idle    = (state_q == S_IDLE);
  assign ctrl_wr = reg_we && (reg_addr == 2'd3);
  // Start is only meaningful from IDLE; a start while copying is dropped.
  assign start   = ctrl_wr && reg_data[0] && idle;
  assign busy    = !idle;
  assign irq     = done_q;

  // Register readback shows the programmed values, never the working copies.
  always_comb begin
    reg_q = 32'd0;
    case (reg_addr)
      2'd0:    reg_q = src_q;
      2'd1:    reg_q = dst_q;
      2'd2:    reg_q = 32'(len_q);
      default: reg_q = {30'd0, done_q, busy};
    endcase
  end

  // State register; reset forces IDLE so m_valid drops immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and bus outputs; bus outputs are zero outside the two request states.
  always_comb begin
    state_d = state_q;
    m_valid = 1'b0;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    m_wstrb = 4'h0;
    case (state_q)
      S_IDLE: begin
        if (start && (len_q != '0)) state_d = S_RD;
      end
      S_RD: begin
        m_valid = 1'b1;
        m_addr  = wsrc_q;
        if (m_ready) state_d = S_RGAP;
      end
      S_RGAP: begin
        // Responders derive ready from a registered select, so they need an idle cycle.
        state_d = S_WR;
      end
      S_WR: begin
        m_valid = 1'b1;
        m_addr  = wdst_q;
        m_wdata = buf_q;
        m_wstrb = 4'hF;
        if (m_ready) state_d = S_WGAP;
      end
      S_WGAP: begin
        state_d = (cnt_q == '0) ? S_IDLE : S_RD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Programmed registers; frozen while a copy is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= 32'd0;
      dst_q <= 32'd0;
      len_q <= '0;
    end else if (reg_we && idle) begin
      case (reg_addr)
        2'd0:    src_q <= {reg_data[31:2], 2'b00};
        2'd1:    dst_q <= {reg_data[31:2], 2'b00};
        2'd2:    len_q <= reg_data[LEN_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Working address/count registers and the one-word data buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wsrc_q <= 32'd0;
      wdst_q <= 32'd0;
      cnt_q  <= '0;
      buf_q  <= 32'd0;
    end else if (start) begin
      wsrc_q <= src_q;
      wdst_q <= dst_q;
      cnt_q  <= len_q;
    end else if ((state_q == S_RD) && m_ready) begin
      buf_q <= m_rdata;
    end else if ((state_q == S_WR) && m_ready) begin
      // Plain 32-bit arithmetic: wrapping past FFFF_FFFC is allowed.
      wsrc_q <= wsrc_q + 32'd4;
      wdst_q <= wdst_q + 32'd4;
      cnt_q  <= cnt_q - LEN_WIDTH'(1);
    end
  end

  // Done flag: set on completion (or a zero-length start), cleared by start or write-1-to-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else if (start) begin
      done_q <= (len_q == '0);
    end else if ((state_q == S_WGAP) && (cnt_q == '0)) begin
      done_q <= 1'b1;
    end else if (ctrl_wr && reg_data[1]) begin
      done_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dma_copy.sv
// Bench for dma_copy: randomized copies against a beat-list reference model.
// Latency: checks 1-cycle start latency and 6-cycle-per-word throughput.
// Backpressure: a responder with 1-cycle ready plus optional stalls.
module tb_dma_copy;

  logic        clk;
  logic        rst_n;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [31:0] reg_data;
  logic [31:0] reg_q;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        irq;
  logic        busy;

  dma_copy #(.LEN_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .reg_we(reg_we), .reg_addr(reg_addr),
    .reg_data(reg_data), .reg_q(reg_q), .m_valid(m_valid), .m_ready(m_ready),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata),
    .irq(irq), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Observed beats, logged by the responder.
  logic [31:0] log_addr[$];
  bit          log_wr[$];
  logic [31:0] log_data[$];

  int          stall_mode   = 0;  // 0 none, 1 fixed extra on one read, 2 random
  int          stall_rd_idx = 0;
  int          rd_idx       = 0;
  logic [31:0] rd_base      = 32'd0;
  int          wr_done      = 0;
  int          last_wr_cyc  = 0;
  int          irq_rise_cyc = 0;
  int          low_cnt      = 0;
  bit          seen_beat    = 0;
  int          valid_hi_cnt = 0;
  int          start_cyc    = 0;

  // Responder and bus monitor: ready one cycle after request (plus stalls), data = base + read index.
  initial begin
    bit          prev_v   = 0;
    bit          prev_irq = 0;
    bit          in_req   = 0;
    int          stall    = 0;
    logic [31:0] h_addr, h_wdata;
    logic [3:0]  h_wstrb;
    m_ready = 1'b0;
    m_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (irq && !prev_irq) irq_rise_cyc = cyc;
      prev_irq = irq;
      if (m_valid) valid_hi_cnt++;
      if (m_valid && !prev_v && seen_beat) begin
        n_checks++;
        if (low_cnt != 1) begin
          n_fail++;
          $display("FAIL gap: m_valid low for %0d cycles, required 1", low_cnt);
        end
      end
      if (!m_valid) low_cnt++; else low_cnt = 0;
      prev_v = m_valid;
      if (in_req && !m_valid && rst_n) begin
        n_checks++;
        n_fail++;
        $display("FAIL valid_drop: m_valid fell before m_ready at addr %h", h_addr);
      end
      if (!m_valid) in_req = 0;
      if (m_ready) begin
        m_ready = 1'b0;
        seen_beat = 1;
        if (log_wr.size() > 0 && log_wr[$]) begin
          wr_done++;
          last_wr_cyc = cyc;
        end
      end else if (m_valid) begin
        if (!in_req) begin
          in_req  = 1;
          h_addr  = m_addr;
          h_wstrb = m_wstrb;
          h_wdata = m_wdata;
          stall   = 1;
          if (stall_mode == 1 && m_wstrb == 4'h0 && rd_idx == stall_rd_idx) stall += 5;
          if (stall_mode == 2) stall += $urandom_range(0, 3);
        end else begin
          n_checks++;
          if (m_addr !== h_addr || m_wstrb !== h_wstrb || m_wdata !== h_wdata) begin
            n_fail++;
            $display("FAIL hold: addr %h wstrb %h wdata %h, required %h %h %h",
                     m_addr, m_wstrb, m_wdata, h_addr, h_wstrb, h_wdata);
          end
        end
        if (stall > 0) begin
          stall--;
        end else begin
          m_ready = 1'b1;
          in_req  = 0;
          log_addr.push_back(m_addr);
          log_wr.push_back(m_wstrb == 4'hF);
          if (m_wstrb == 4'hF) begin
            log_data.push_back(m_wdata);
          end else begin
            m_rdata = rd_base + 32'(rd_idx);
            log_data.push_back(m_rdata);
            rd_idx++;
          end
        end
      end
    end
  end

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_we = 1'b1; reg_addr = a; reg_data = d;
    @(negedge clk);
    reg_we = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    reg_addr = a;
    #1 d = reg_q;
  endtask

  task automatic clear_log(input logic [31:0] base);
    log_addr.delete(); log_wr.delete(); log_data.delete();
    rd_idx = 0; rd_base = base; seen_beat = 0; low_cnt = 0; wr_done = 0; valid_hi_cnt = 0;
  endtask

  // Program and start; checks the first request appears one cycle after the start edge.
  task automatic start_copy(input string nm, input logic [31:0] s, input logic [31:0] d,
                            input int len, input logic [31:0] base);
    clear_log(base);
    reg_write(2'd0, s);
    reg_write(2'd1, d);
    reg_write(2'd2, 32'(len));
    reg_write(2'd3, 32'h1);
    start_cyc = cyc;
    n_checks++;
    if (m_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s start_latency: m_valid=%b busy=%b, required 1 1", nm, m_valid, busy);
    end
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (irq !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: irq=%b after %0d cycles, required 1", nm, irq, t);
    end
  endtask

  // Reference model: read src+4i (data base+i), then write dst+4i with that data, in order.
  task automatic check_copy(input string nm, input logic [31:0] s, input logic [31:0] d,
                            input int len, input logic [31:0] base);
    logic [31:0] ea, ed;
    n_checks++;
    if (log_addr.size() != 2 * len) begin
      n_fail++;
      $display("FAIL %s beats: got %0d beats, required %0d", nm, log_addr.size(), 2 * len);
      return;
    end
    for (int i = 0; i < len; i++) begin
      for (int k = 0; k < 2; k++) begin
        ea = (k == 1) ? d + 32'(4 * i) : s + 32'(4 * i);
        ed = base + 32'(i);
        n_checks++;
        if (log_addr[2*i+k] !== ea || log_wr[2*i+k] != bit'(k) || log_data[2*i+k] !== ed) begin
          n_fail++;
          $display("FAIL %s beat%0d: addr %h wr %0d data %h, required %h %0d %h", nm, 2*i+k,
                   log_addr[2*i+k], log_wr[2*i+k], log_data[2*i+k], ea, k, ed);
        end
      end
    end
  endtask

  task automatic check_regs_zero(input string nm);
    logic [31:0] v;
    for (int a = 0; a < 4; a++) begin
      reg_read(2'(a), v);
      n_checks++;
      if (v !== 32'd0) begin
        n_fail++;
        $display("FAIL %s reg%0d: got %h, required 0", nm, a, v);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; reg_we = 1'b0; reg_addr = 2'd0; reg_data = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_regs_zero("reset");
    n_checks++;
    if (m_valid !== 1'b0 || irq !== 1'b0 || busy !== 1'b0 ||
        m_addr !== 32'd0 || m_wdata !== 32'd0 || m_wstrb !== 4'h0) begin
      n_fail++;
      $display("FAIL reset outputs: v=%b irq=%b busy=%b addr=%h wdata=%h wstrb=%h, required all 0",
               m_valid, irq, busy, m_addr, m_wdata, m_wstrb);
    end
  endtask

  task automatic test_basic();
    logic [31:0] v;
    stall_mode = 0;
    start_copy("basic", 32'h1000, 32'h2000, 4, 32'hA0);
    wait_done("basic");
    check_copy("basic", 32'h1000, 32'h2000, 4, 32'hA0);
    n_checks++;
    if (irq_rise_cyc != last_wr_cyc + 1 || irq_rise_cyc != start_cyc + 24) begin
      n_fail++;
      $display("FAIL basic irq_timing: irq at %0d, required %0d (last write %0d)",
               irq_rise_cyc - start_cyc, 24, last_wr_cyc - start_cyc);
    end
    reg_read(2'd3, v);
    n_checks++;
    if (v !== 32'h2) begin
      n_fail++;
      $display("FAIL basic ctrl: got %h, required 2", v);
    end
  endtask

  task automatic test_stall();
    stall_mode = 1; stall_rd_idx = 1;
    start_copy("stall", 32'h3000, 32'h4000, 3, 32'h1111_0000);
    wait_done("stall");
    check_copy("stall", 32'h3000, 32'h4000, 3, 32'h1111_0000);
    n_checks++;
    if (valid_hi_cnt != 4 * 3 + 5) begin
      n_fail++;
      $display("FAIL stall valid_cycles: got %0d, required %0d", valid_hi_cnt, 17);
    end
    stall_mode = 0;
  endtask

  task automatic test_busy_ignore();
    logic [31:0] v;
    start_copy("busy", 32'h5000, 32'h6000, 4, 32'h0BAD_0000);
    repeat (3) @(negedge clk);
    reg_write(2'd2, 32'd9);
    reg_write(2'd3, 32'h1);
    reg_read(2'd2, v);
    n_checks++;
    if (v !== 32'd4) begin
      n_fail++;
      $display("FAIL busy len_readback: got %h, required 4", v);
    end
    reg_read(2'd3, v);
    n_checks++;
    if (v !== 32'h1) begin
      n_fail++;
      $display("FAIL busy ctrl: got %h, required 1", v);
    end
    wait_done("busy");
    check_copy("busy", 32'h5000, 32'h6000, 4, 32'h0BAD_0000);
  endtask

  task automatic test_len_zero();
    logic [31:0] v;
    clear_log(32'd0);
    reg_write(2'd2, 32'd0);
    reg_write(2'd3, 32'h1);
    reg_addr = 2'd3;
    #1;
    n_checks++;
    if (reg_q !== 32'h2) begin
      n_fail++;
      $display("FAIL len0 ctrl: got %h, required 2", reg_q);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (valid_hi_cnt != 0) begin
      n_fail++;
      $display("FAIL len0 traffic: %0d request cycles, required 0", valid_hi_cnt);
    end
    reg_write(2'd3, 32'h2);
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL len0 clear: irq=%b, required 0", irq);
    end
    // Start and clear together: start wins, done stays low while copying.
    reg_write(2'd2, 32'd1);
    reg_write(2'd3, 32'h1);
    reg_write(2'd3, 32'h0);
    clear_log(32'h77);
    reg_write(2'd3, 32'h3);
    reg_read(2'd3, v);
    n_checks++;
    if (v !== 32'h1) begin
      n_fail++;
      $display("FAIL start_clear ctrl: got %h, required 1", v);
    end
    wait_done("start_clear");
  endtask

  task automatic test_reset_mid();
    int t = 0;
    int n_log;
    start_copy("rstmid", 32'h7000, 32'h8000, 4, 32'h5500);
    while (!(m_valid === 1'b1 && m_wstrb === 4'hF && wr_done == 1) && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= 200) begin
      n_fail++;
      $display("FAIL rstmid wait: second write not seen, wr_done=%0d", wr_done);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid async: m_valid=%b, required 0", m_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_log = log_addr.size();
    valid_hi_cnt = 0;
    n_checks++;
    if (busy !== 1'b0 || irq !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid flags: busy=%b irq=%b, required 0 0", busy, irq);
    end
    check_regs_zero("rstmid");
    repeat (20) @(negedge clk);
    n_checks++;
    if (valid_hi_cnt != 0 || log_addr.size() != n_log) begin
      n_fail++;
      $display("FAIL rstmid quiet: %0d request cycles, %0d new beats, required 0 0",
               valid_hi_cnt, log_addr.size() - n_log);
    end
  endtask

  task automatic test_wrap();
    start_copy("wrap", 32'hFFFF_FFFC, 32'h9000, 2, 32'hC0DE_0000);
    wait_done("wrap");
    check_copy("wrap", 32'hFFFF_FFFC, 32'h9000, 2, 32'hC0DE_0000);
  endtask

  task automatic test_random();
    logic [31:0] s, d, base;
    int len;
    stall_mode = 2;
    for (int n = 0; n < 6; n++) begin
      s    = $urandom & 32'hFFFF_FFFC;
      d    = $urandom & 32'hFFFF_FFFC;
      base = $urandom;
      len  = $urandom_range(1, 5);
      start_copy("random", s, d, len, base);
      wait_done("random");
      check_copy("random", s, d, len, base);
    end
    stall_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_busy_ignore();
    test_len_zero();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
